// File: rtl/cmp_pkg.sv
// Shared definitions for the stream equality checker: parameter defaults
// and the status (FSM state) encoding.
package cmp_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef logic [1:0] status_t;

  localparam status_t ST_IDLE = 2'd0;
  localparam status_t ST_PASS = 2'd1;
  localparam status_t ST_FAIL = 2'd2;

endpackage

// File: rtl/cmp_mag.sv
// Combinational unsigned magnitude compare of two WIDTH-bit operands.
module cmp_mag #(
  parameter int WIDTH = cmp_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/stream_equality_checker.sv
// Compares an a/b sample stream, registers eq/gt/lt, counts samples and
// mismatches, and tracks a sticky PASS/FAIL status. Define
// STREAM_EQ_CAPTURE_EN to add first-mismatch capture outputs.
module stream_equality_checker
  import cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clear,
  output logic             out_valid,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [CNT_W-1:0] cmp_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
`ifdef STREAM_EQ_CAPTURE_EN
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [CNT_W-1:0] first_idx,
`endif
  output logic [1:0]       status
);

  logic    mag_eq, mag_gt, mag_lt;
  logic    accept;
  status_t state, state_next;

  cmp_mag #(.WIDTH(WIDTH)) u_cmp_mag (
    .a  (a),
    .b  (b),
    .eq (mag_eq),
    .gt (mag_gt),
    .lt (mag_lt)
  );

  // clear drops any sample presented in the same cycle
  assign accept = in_valid & ~clear;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    if (accept) begin
      case (state)
        ST_IDLE: state_next = mag_eq ? ST_PASS : ST_FAIL;
        ST_PASS: state_next = mag_eq ? ST_PASS : ST_FAIL;
        default: state_next = ST_FAIL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      eq           <= 1'b0;
      gt           <= 1'b0;
      lt           <= 1'b0;
      cmp_cnt      <= '0;
      mismatch_cnt <= '0;
      state        <= ST_IDLE;
    end else if (clear) begin
      out_valid    <= 1'b0;
      cmp_cnt      <= '0;
      mismatch_cnt <= '0;
      state        <= ST_IDLE;
    end else begin
      out_valid <= accept;
      state     <= state_next;
      if (accept) begin
        eq      <= mag_eq;
        gt      <= mag_gt;
        lt      <= mag_lt;
        cmp_cnt <= sat_inc(cmp_cnt);
        if (!mag_eq) mismatch_cnt <= sat_inc(mismatch_cnt);
      end
    end
  end

  assign status = state;

`ifdef STREAM_EQ_CAPTURE_EN
  // FAIL is entered only by a mismatch and left only by rst/clear, so any
  // mismatch seen outside FAIL is the first one.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      first_a   <= '0;
      first_b   <= '0;
      first_idx <= '0;
    end else if (accept && !mag_eq && state != ST_FAIL) begin
      first_a   <= a;
      first_b   <= b;
      first_idx <= cmp_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_stream_equality_checker.sv
// Directed, table-driven bench for stream_equality_checker (WIDTH=8) with a
// second CNT_W=2 instance for counter saturation.
module tb_stream_equality_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic        out_valid, eq, gt, lt;
  logic [15:0] cmp_cnt, mismatch_cnt;
  logic [1:0]  status;

  logic        s_out_valid, s_eq, s_gt, s_lt;
  logic [1:0]  s_cmp_cnt, s_mismatch_cnt;
  logic [1:0]  s_status;

`ifdef STREAM_EQ_CAPTURE_EN
  logic [7:0]  first_a, first_b;
  logic [15:0] first_idx;
  logic [7:0]  s_first_a, s_first_b;
  logic [1:0]  s_first_idx;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_equality_checker #(.WIDTH(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .a            (a),
    .b            (b),
    .clear        (clear),
    .out_valid    (out_valid),
    .eq           (eq),
    .gt           (gt),
    .lt           (lt),
    .cmp_cnt      (cmp_cnt),
    .mismatch_cnt (mismatch_cnt),
`ifdef STREAM_EQ_CAPTURE_EN
    .first_a      (first_a),
    .first_b      (first_b),
    .first_idx    (first_idx),
`endif
    .status       (status)
  );

  stream_equality_checker #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .a            (a),
    .b            (b),
    .clear        (clear),
    .out_valid    (s_out_valid),
    .eq           (s_eq),
    .gt           (s_gt),
    .lt           (s_lt),
    .cmp_cnt      (s_cmp_cnt),
    .mismatch_cnt (s_mismatch_cnt),
`ifdef STREAM_EQ_CAPTURE_EN
    .first_a      (s_first_a),
    .first_b      (s_first_b),
    .first_idx    (s_first_idx),
`endif
    .status       (s_status)
  );

  typedef struct {
    logic        clr;
    logic        iv;
    logic [7:0]  va;
    logic [7:0]  vb;
    logic        ov;
    logic        eq;
    logic        gt;
    logic        lt;
    logic [15:0] cnt;
    logic [15:0] mm;
    logic [1:0]  st;
    logic [7:0]  fa;
    logic [7:0]  fb;
    logic [15:0] fi;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic clr_i, iv_i, input logic [7:0] a_i, b_i,
                              input logic ov_i, eq_i, gt_i, lt_i,
                              input logic [15:0] cnt_i, mm_i, input logic [1:0] st_i,
                              input logic [7:0] fa_i, fb_i, input logic [15:0] fi_i);
    vec_t v;
    v.clr = clr_i; v.iv = iv_i; v.va = a_i; v.vb = b_i;
    v.ov = ov_i; v.eq = eq_i; v.gt = gt_i; v.lt = lt_i;
    v.cnt = cnt_i; v.mm = mm_i; v.st = st_i;
    v.fa = fa_i; v.fb = fb_i; v.fi = fi_i;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic step(input logic rst_i, clr_i, iv_i, input logic [7:0] a_i, b_i);
    @(negedge clk);
    rst = rst_i; clear = clr_i; in_valid = iv_i; a = a_i; b = b_i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // status: 0=IDLE 1=PASS 2=FAIL
    //                 clr iv  a    b    ov eq gt lt cnt mm st fa   fb   fi
    vecs.push_back(mk(0, 1,   5,   5, 1, 1, 0, 0, 1, 0, 1,  0,   0, 0));
    vecs.push_back(mk(0, 1,   9,   3, 1, 0, 1, 0, 2, 1, 2,  9,   3, 1));
    vecs.push_back(mk(0, 1,   2, 200, 1, 0, 0, 1, 3, 2, 2,  9,   3, 1));
    vecs.push_back(mk(0, 0,   0,   0, 0, 0, 0, 1, 3, 2, 2,  9,   3, 1));
    vecs.push_back(mk(1, 1,   1,   2, 0, 0, 0, 1, 0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(0, 0,   0,   0, 0, 0, 0, 1, 0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(0, 1,  10,  10, 1, 1, 0, 0, 1, 0, 1,  0,   0, 0));
    vecs.push_back(mk(0, 1,   0,   0, 1, 1, 0, 0, 2, 0, 1,  0,   0, 0));
    vecs.push_back(mk(0, 1, 255, 255, 1, 1, 0, 0, 3, 0, 1,  0,   0, 0));
    vecs.push_back(mk(0, 1,  77,  77, 1, 1, 0, 0, 4, 0, 1,  0,   0, 0));
    vecs.push_back(mk(0, 1,   0, 255, 1, 0, 0, 1, 5, 1, 2,  0, 255, 4));
    vecs.push_back(mk(0, 1,   3,   3, 1, 1, 0, 0, 6, 1, 2,  0, 255, 4));
    vecs.push_back(mk(0, 1,   4,   4, 1, 1, 0, 0, 7, 1, 2,  0, 255, 4));
    vecs.push_back(mk(0, 1, 200, 200, 1, 1, 0, 0, 8, 1, 2,  0, 255, 4));
    vecs.push_back(mk(1, 0,   0,   0, 0, 1, 0, 0, 0, 0, 0,  0,   0, 0));
    vecs.push_back(mk(0, 1,   7,   7, 1, 1, 0, 0, 1, 0, 1,  0,   0, 0));
    vecs.push_back(mk(0, 1,   8,   9, 1, 0, 0, 1, 2, 1, 2,  8,   9, 1));
    vecs.push_back(mk(0, 1,   1,   0, 1, 0, 1, 0, 3, 2, 2,  8,   9, 1));

    // Reset held for two edges, then one idle cycle.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.flags", {eq, gt, lt}, 3'b000);
    check("reset.cmp_cnt", cmp_cnt, 16'd0);
    check("reset.mismatch_cnt", mismatch_cnt, 16'd0);
    check("reset.status", status, 2'd0);
`ifdef STREAM_EQ_CAPTURE_EN
    check("reset.first", {first_a, first_b, first_idx}, 32'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      step(0, vecs[i].clr, vecs[i].iv, vecs[i].va, vecs[i].vb);
      check($sformatf("row%0d.out_valid", i), out_valid, vecs[i].ov);
      check($sformatf("row%0d.eq", i), eq, vecs[i].eq);
      check($sformatf("row%0d.gt", i), gt, vecs[i].gt);
      check($sformatf("row%0d.lt", i), lt, vecs[i].lt);
      check($sformatf("row%0d.cmp_cnt", i), cmp_cnt, vecs[i].cnt);
      check($sformatf("row%0d.mismatch_cnt", i), mismatch_cnt, vecs[i].mm);
      check($sformatf("row%0d.status", i), status, vecs[i].st);
`ifdef STREAM_EQ_CAPTURE_EN
      check($sformatf("row%0d.first_a", i), first_a, vecs[i].fa);
      check($sformatf("row%0d.first_b", i), first_b, vecs[i].fb);
      check($sformatf("row%0d.first_idx", i), first_idx, vecs[i].fi);
`endif
    end

    // Reset mid-stream: the sample presented alongside rst yields no result.
    step(0, 0, 1, 5, 5);
    check("midrst.pre_out_valid", out_valid, 1'b1);
    step(1, 0, 1, 6, 7);
    check("midrst.out_valid", out_valid, 1'b0);
    check("midrst.flags", {eq, gt, lt}, 3'b000);
    check("midrst.counts", {cmp_cnt, mismatch_cnt}, 32'd0);
    check("midrst.status", status, 2'd0);
    step(0, 0, 0, 0, 0);
    check("midrst.after_out_valid", out_valid, 1'b0);
    check("midrst.after_cmp_cnt", cmp_cnt, 16'd0);

    // Saturation of the 2-bit counters over six unequal pairs.
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 8'(i), 8'(i + 1));
      check($sformatf("sat%0d.cmp_cnt", i), s_cmp_cnt, (i + 1 > 3) ? 2'd3 : 2'(i + 1));
      check($sformatf("sat%0d.mismatch_cnt", i), s_mismatch_cnt, (i + 1 > 3) ? 2'd3 : 2'(i + 1));
      check($sformatf("sat%0d.lt", i), {s_out_valid, s_eq, s_gt, s_lt}, 4'b1001);
    end
    check("sat.status", s_status, 2'd2);
    check("sat.wide_cmp_cnt", cmp_cnt, 16'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_equality_checker.md
STREAM_EQUALITY_CHECKER -- requirements
Module: stream_equality_checker

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: operand width in bits, legal range 1..64.
REQ-002 SHALL provide parameter CNT_W, default 16: width of the compare and mismatch counters, legal range 2..32.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL provide port in_valid, input, 1 bit: a/b hold a sample pair this cycle.
REQ-006 SHALL provide port a, input, WIDTH bits: operand A, unsigned.
REQ-007 SHALL provide port b, input, WIDTH bits: operand B, unsigned.
REQ-008 SHALL provide port clear, input, 1 bit: synchronous soft clear of counters, flags and state.
REQ-009 SHALL provide port out_valid, output, 1 bit: eq/gt/lt hold a result this cycle.
REQ-010 SHALL provide ports eq, gt and lt, outputs, 1 bit each: registered result of a==b, a>b and a<b.
REQ-011 SHALL provide port cmp_cnt, output, CNT_W bits: number of samples accepted.
REQ-012 SHALL provide port mismatch_cnt, output, CNT_W bits: number of accepted samples with a!=b.
REQ-013 SHALL provide port status, output, 2 bits: FSM state, with IDLE=0, PASS=1, FAIL=2.

Function
REQ-014 SHALL accept a sample on every cycle with in_valid=1 and clear=0, with no backpressure.
REQ-015 SHALL assert out_valid exactly 1 cycle after each accepted sample; eq, gt and lt for that sample SHALL appear in the same cycle.
REQ-016 SHALL ensure exactly one of eq, gt and lt is 1 whenever out_valid=1.
REQ-017 SHALL hold eq, gt and lt at their last values while out_valid=0.
REQ-018 SHALL increment cmp_cnt on each accepted sample and mismatch_cnt on each accepted sample with a!=b; both counters SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-019 SHALL implement FSM transitions IDLE->PASS on an accepted equal sample, IDLE->FAIL on an accepted unequal sample, PASS->FAIL on an accepted unequal sample, and FAIL->FAIL on any sample; FAIL SHALL be sticky.
REQ-020 SHALL give clear priority over in_valid: a sample presented in the same cycle as clear is dropped, and out_valid=0 on the next cycle.
REQ-021 SHALL, on clear, zero both counters, set the FSM to IDLE and hold eq/gt/lt unchanged.
REQ-022 SHALL update counters and status registered, in the same cycle out_valid rises.

Reset
REQ-023 SHALL, with rst=1 at a clock edge, set out_valid=0, eq=0, gt=0, lt=0, cmp_cnt=0, mismatch_cnt=0 and status=IDLE.
REQ-024 SHALL give rst priority over clear and in_valid; a sample in flight during reset SHALL be discarded with no out_valid pulse.

Configuration
REQ-025 SHALL compile first-mismatch capture logic only when macro STREAM_EQ_CAPTURE_EN is defined.
REQ-026 SHALL, with STREAM_EQ_CAPTURE_EN defined, add outputs first_a[WIDTH], first_b[WIDTH] and first_idx[CNT_W], latched on the first accepted mismatch after reset or clear (first_idx = cmp_cnt value before increment) and zeroed by rst or clear.
REQ-027 SHALL, without STREAM_EQ_CAPTURE_EN, omit those ports and registers; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL place the status encoding type (IDLE/PASS/FAIL) and the WIDTH/CNT_W defaults in shared package cmp_pkg.
REQ-029 SHALL implement the combinational magnitude compare (eq/gt/lt from a,b) as sub-module cmp_mag, parametrised by WIDTH and instantiated once.

Verification
REQ-030 SHALL verify: rst held 2 cycles, then idle -> all outputs 0, status=IDLE.
REQ-031 SHALL verify, with WIDTH=8: pairs (5,5), (9,3), (2,200) on consecutive cycles -> out_valid for 3 cycles, giving eq, gt, lt in turn; cmp_cnt=3, mismatch_cnt=2, status=FAIL.
REQ-032 SHALL verify: 4 equal pairs then 1 pair (0,255) -> status PASS after the first result and FAIL after the fifth; FAIL SHALL persist through 3 further equal pairs.
REQ-033 SHALL verify, with CNT_W=2: 6 unequal pairs -> mismatch_cnt and cmp_cnt saturate at 3.
REQ-034 SHALL verify: clear and in_valid asserted together with (1,2) -> no out_valid, counters 0, status=IDLE; rst asserted mid-stream -> no result for the in-flight sample.
REQ-035 SHALL verify, with STREAM_EQ_CAPTURE_EN defined: pairs (7,7), (8,9), (1,0) -> first_a=8, first_b=9, first_idx=1, values unchanged by the later mismatch.
